// File: rtl/sobel_operator.sv
// sobel_operator: streaming 3x3 Sobel edge detector, |Gx|+|Gy| saturated to 8 bits
// for every interior pixel of a raster-order frame, with a sticky frame-done flag.
module sobel_operator #(
    parameter int WIDTH          = 768,
    parameter int HEIGHT         = 512,
    parameter int BITS_FOR_INDEX = 10,
    parameter     INFILE         = "outputSorbel.bmp"
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic [BITS_FOR_INDEX-1:0] rowIndex,
    input  logic [BITS_FOR_INDEX-1:0] colIndex,
    input  logic [7:0]                DATA_WRITE_R0,
    input  logic                      DATA_VALID,
    output logic [7:0]                SOBEL_OUT,
    output logic                      OUT_VALID,
    output logic [BITS_FOR_INDEX-1:0] OUT_ROW,
    output logic [BITS_FOR_INDEX-1:0] OUT_COL,
    output logic                      Write_Done
);
    localparam int AW = $clog2(WIDTH);
    localparam int unused_infile_bits = $bits(INFILE);
    localparam logic [BITS_FOR_INDEX-1:0] LAST_ROW = BITS_FOR_INDEX'(HEIGHT - 2);
    localparam logic [BITS_FOR_INDEX-1:0] LAST_COL = BITS_FOR_INDEX'(WIDTH - 2);
    localparam logic [BITS_FOR_INDEX-1:0] TWO      = BITS_FOR_INDEX'(2);
    localparam logic [BITS_FOR_INDEX-1:0] ZERO     = '0;

    logic [AW-1:0] col_a;
    logic [7:0] lb1 [WIDTH];
    logic [7:0] lb2 [WIDTH];
    logic [7:0] w [3][3];
    logic s1_valid, s1_emit, s1_start;
    logic [BITS_FOR_INDEX-1:0] s1_row, s1_col;
    logic [9:0] gx_p, gx_n, gy_p, gy_n;
    logic [10:0] gx, gy, ax, ay, mag;
    logic [7:0] sat;
    logic fire;

    assign col_a = colIndex[AW-1:0];
    assign fire  = s1_valid && s1_emit;

    // lb1 holds row r-1, lb2 row r-2; no reset, rows 0..1 are never emitted
    always_ff @(posedge HCLK) begin
        if (DATA_VALID) begin
            lb2[col_a] <= lb1[col_a];
            lb1[col_a] <= DATA_WRITE_R0;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESETn) begin
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    w[i][j] <= '0;
            s1_valid <= 1'b0;
            s1_emit  <= 1'b0;
            s1_start <= 1'b0;
            s1_row   <= '0;
            s1_col   <= '0;
        end else begin
            s1_valid <= DATA_VALID;
            if (DATA_VALID) begin
                for (int i = 0; i < 3; i++) begin
                    w[i][0] <= w[i][1];
                    w[i][1] <= w[i][2];
                end
                w[0][2]  <= lb2[col_a];
                w[1][2]  <= lb1[col_a];
                w[2][2]  <= DATA_WRITE_R0;
                s1_emit  <= rowIndex >= TWO && colIndex >= TWO;
                s1_start <= rowIndex == ZERO && colIndex == ZERO;
                s1_row   <= rowIndex - 1'b1;
                s1_col   <= colIndex - 1'b1;
            end
        end
    end

    // differences are taken modulo 2^11, giving the two's-complement gradient directly
    always_comb begin
        gx_p = 10'(w[0][2]) + 10'({w[1][2], 1'b0}) + 10'(w[2][2]);
        gx_n = 10'(w[0][0]) + 10'({w[1][0], 1'b0}) + 10'(w[2][0]);
        gy_p = 10'(w[2][0]) + 10'({w[2][1], 1'b0}) + 10'(w[2][2]);
        gy_n = 10'(w[0][0]) + 10'({w[0][1], 1'b0}) + 10'(w[0][2]);
        gx   = 11'(gx_p) - 11'(gx_n);
        gy   = 11'(gy_p) - 11'(gy_n);
        ax   = gx[10] ? -gx : gx;
        ay   = gy[10] ? -gy : gy;
        mag  = ax + ay;
        sat  = |mag[10:8] ? 8'hff : mag[7:0];
    end

    always_ff @(posedge HCLK) begin
        if (HRESETn) begin
            SOBEL_OUT  <= '0;
            OUT_VALID  <= 1'b0;
            OUT_ROW    <= '0;
            OUT_COL    <= '0;
            Write_Done <= 1'b0;
        end else begin
            OUT_VALID <= fire;
            if (fire) begin
                SOBEL_OUT <= sat;
                OUT_ROW   <= s1_row;
                OUT_COL   <= s1_col;
            end
            // frame start is handled here, in pipeline order with the last result
            if (fire && s1_row == LAST_ROW && s1_col == LAST_COL)
                Write_Done <= 1'b1;
            else if (s1_valid && s1_start)
                Write_Done <= 1'b0;
        end
    end
endmodule

// File: tb/tb_sobel_operator.sv
// tb_sobel_operator: directed-frame bench for sobel_operator on an 8x6 image.
module tb_sobel_operator;
    localparam int W = 8, H = 6, BI = 10;
    localparam int NRES = (H - 2) * (W - 2);

    logic clk = 1'b0, rst = 1'b1, dv = 1'b0;
    logic [BI-1:0] row = '0, col = '0;
    logic [7:0] pix = '0;
    logic [7:0] sobel;
    logic ov, done;
    logic [BI-1:0] orow, ocol;

    int checks = 0, failures = 0, cyc = 0;
    bit dv_hist [0:4095];
    bit ov_hist [0:4095];
    int res_q [$];
    int first_edge = -1, done_idx = -1, done_pos = -1;
    logic prev_done = 1'b0;

    always #5 clk = ~clk;

    sobel_operator #(.WIDTH(W), .HEIGHT(H), .BITS_FOR_INDEX(BI), .INFILE("tb_dump.bmp")) dut (
        .HCLK(clk), .HRESETn(rst), .rowIndex(row), .colIndex(col), .DATA_WRITE_R0(pix),
        .DATA_VALID(dv), .SOBEL_OUT(sobel), .OUT_VALID(ov), .OUT_ROW(orow), .OUT_COL(ocol),
        .Write_Done(done));

    always @(posedge clk) begin
        dv_hist[cyc] = dv;
        cyc = cyc + 1;
    end

    always @(negedge clk) begin
        ov_hist[cyc-1] = ov;
        if (ov === 1'b1) begin
            res_q.push_back(int'({orow, ocol, sobel}));
            if (first_edge < 0) first_edge = cyc - 1;
        end
        if (done === 1'b1 && prev_done !== 1'b1) begin
            done_idx = res_q.size();
            done_pos = int'({orow, ocol});
        end
        prev_done = done;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pix_of(input int kind, input int r, input int c);
        case (kind)
            0: return 77;
            1: return c < 4 ? 10 : 20;
            2: return r < 3 ? 0 : 50;
            default: return (r == 2 && c == 2) ? 255 : 0;
        endcase
    endfunction

    function automatic int exp_of(input int kind, input int r, input int c);
        case (kind)
            0: return 0;
            1: return (c == 3 || c == 4) ? 40 : 0;
            2: return (r == 2 || r == 3) ? 200 : 0;
            default: return (r >= 1 && r <= 3 && c >= 1 && c <= 3 && !(r == 2 && c == 2)) ? 255 : 0;
        endcase
    endfunction

    task automatic drive(input int r, input int c, input int v, input logic valid);
        row = BI'(r);
        col = BI'(c);
        pix = 8'(v);
        dv  = valid;
        @(negedge clk);
    endtask

    task automatic run_frame(input int kind, input bit gap);
        int acc, s, e, bad, k;
        k = 0;
        acc = -1;
        res_q.delete();
        first_edge = -1;
        done_idx = -1;
        s = cyc;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                if (gap && k % 3 == 2) begin
                    drive(0, 0, 0, 1'b0);
                    k++;
                end
                drive(r, c, pix_of(kind, r, c), 1'b1);
                k++;
                if (r == 2 && c == 2) acc = cyc - 1;
            end
        e = cyc;
        repeat (3) drive(0, 0, 0, 1'b0);
        chk($sformatf("k%0d count", kind), res_q.size(), NRES);
        for (int i = 0; i < res_q.size() && i < NRES; i++) begin
            int er, ec;
            er = 1 + i / (W - 2);
            ec = 1 + i % (W - 2);
            chk($sformatf("k%0d res r%0d c%0d", kind, er, ec), res_q[i], (er << 18) | (ec << 8) | exp_of(kind, er, ec));
        end
        chk($sformatf("k%0d latency", kind), first_edge, acc + 1);
        chk($sformatf("k%0d done_idx", kind), done_idx, NRES);
        chk($sformatf("k%0d done_pos", kind), done_pos, ((H - 2) << BI) | (W - 2));
        chk($sformatf("k%0d done_sticky", kind), done, 1);
        chk($sformatf("k%0d idle_ov", kind), ov, 0);
        chk($sformatf("k%0d hold_row", kind), orow, H - 2);
        chk($sformatf("k%0d hold_col", kind), ocol, W - 2);
        chk($sformatf("k%0d hold_val", kind), sobel, exp_of(kind, H - 2, W - 2));
        if (gap) begin
            bad = 0;
            for (int n = s; n < e; n++)
                if (!dv_hist[n] && ov_hist[n+1]) bad++;
            chk("gap_ov_low", bad, 0);
        end
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        chk("rst sobel", sobel, 0);
        chk("rst ov", ov, 0);
        chk("rst row", orow, 0);
        chk("rst col", ocol, 0);
        chk("rst done", done, 0);
        rst = 1'b0;
        run_frame(0, 1'b0);
        run_frame(1, 1'b0);
        run_frame(2, 1'b0);
        run_frame(3, 1'b0);
        chk("sat c2_3", (res_q.size() > 8 ? res_q[8] : -1) & 255, 255);
        chk("sat c1_1", (res_q.size() > 0 ? res_q[0] : -1) & 255, 255);
        chk("sat c1_2", (res_q.size() > 1 ? res_q[1] : -1) & 255, 255);
        run_frame(1, 1'b1);
        for (int i = 0; i < 3 * W + 5; i++)
            drive(i / W, i % W, pix_of(1, i / W, i % W), 1'b1);
        rst = 1'b1;
        drive(3, 5, pix_of(1, 3, 5), 1'b1);
        rst = 1'b0;
        chk("midrst sobel", sobel, 0);
        chk("midrst ov", ov, 0);
        chk("midrst row", orow, 0);
        chk("midrst col", ocol, 0);
        chk("midrst done", done, 0);
        drive(0, 0, 0, 1'b0);
        chk("postrst ov", ov, 0);
        chk("postrst done", done, 0);
        run_frame(0, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
